next_pc_unit: RTL and testbench

//  Downstream of the execute ALU: consumes its zero flag plus decode controls, resolves

---
 rtl/core_pkg.sv | 20 ++
 rtl/branch_cond.sv | 31 +++
 rtl/next_pc_unit.sv | 103 ++++++++++
 tb/tb_next_pc_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the next-PC logic: branch funct3 codes, FSM state
// encoding and default reset/trap vectors.
package core_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/branch_cond.sv
// Branch condition resolver. The ALU has already been set up by decode
// (SUB for BEQ/BNE, SLT/SLTU for the ordered compares), so the only
// information needed is its zero flag: for SLT/SLTU a non-zero result
// means "less than".
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] br_funct3,
    input  logic       alu_zero,
    output logic       taken
);

    logic less;

    assign less = ~alu_zero;

    // Decode funct3 into a taken decision; reserved codes never branch.
    always_comb begin
        taken = 1'b0;
        case (br_funct3)
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = ~alu_zero;
            BR_BLT:  taken = less;
            BR_BGE:  taken = ~less;
            BR_BLTU: taken = less;
            BR_BGEU: taken = ~less;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter owner for the single-cycle core: resolves branches, JAL
// and JALR, traps on misaligned redirect targets (4-byte alignment, no
// compressed instructions) and counts retired instructions.
module next_pc_unit
    import core_pkg::*;
#(
    parameter int                     WORD_LENGTH  = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [WORD_LENGTH-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   is_branch,
    input  logic                   is_jal,
    input  logic                   is_jalr,
    input  logic [2:0]             br_funct3,
    input  logic [WORD_LENGTH-1:0] imm,
    input  logic [WORD_LENGTH-1:0] rs1_data,
    input  logic                   alu_zero,
    output logic [WORD_LENGTH-1:0] pc,
    output logic [WORD_LENGTH-1:0] pc_plus4,
    output logic                   trap,
    output logic [WORD_LENGTH-1:0] mepc,
    output logic [63:0]            instret
);

    pc_state_t              state;
    pc_state_t              state_next;
    logic                   taken;
    logic                   redirect;
    logic                   misaligned;
    logic [WORD_LENGTH-1:0] pc_rel_target;
    logic [WORD_LENGTH-1:0] jalr_target;
    logic [WORD_LENGTH-1:0] target;
    logic [WORD_LENGTH-1:0] next_pc;

    branch_cond u_branch_cond (
        .br_funct3 (br_funct3),
        .alu_zero  (alu_zero),
        .taken     (taken)
    );

    assign pc_plus4      = pc + WORD_LENGTH'(4);
    assign pc_rel_target = pc + imm;
    assign jalr_target   = (rs1_data + imm) & ~WORD_LENGTH'(1);

    // Select the redirect target; JALR outranks JAL, which outranks a branch.
    always_comb begin
        target = pc_rel_target;
        if (is_jalr) begin
            target = jalr_target;
        end
    end

    assign redirect   = is_jalr | is_jal | (is_branch & taken);
    assign misaligned = redirect & (target[1:0] != 2'b00);
    assign next_pc    = redirect ? target : pc_plus4;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: a misaligned redirect enters TRAP, TRAP lasts one unstalled cycle.
    always_comb begin
        state_next = state;
        if (!stall) begin
            case (state)
                ST_RUN:  state_next = misaligned ? ST_TRAP : ST_RUN;
                ST_TRAP: state_next = ST_RUN;
                default: state_next = ST_RUN;
            endcase
        end
    end

    // FSM output: trap is visible for the whole time the FSM sits in TRAP.
    always_comb begin
        trap = (state == ST_TRAP);
    end

    // PC, mepc and retired-count update; nothing moves while stalled or trapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_VECTOR;
            mepc    <= '0;
            instret <= '0;
        end else if (!stall && state == ST_RUN) begin
            if (misaligned) begin
                pc   <= TRAP_VECTOR;
                mepc <= pc;
            end else begin
                pc      <= next_pc;
                instret <= instret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: each step drives one instruction's
// controls, clocks once and compares pc/trap/mepc/instret with values
// worked out by hand.
`timescale 1ns/1ps
module tb_next_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  br_funct3;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] mepc;
    logic [63:0] instret;

    int n_cmp;
    int n_err;

    next_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .br_funct3 (br_funct3),
        .imm       (imm),
        .rs1_data  (rs1_data),
        .alu_zero  (alu_zero),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .trap      (trap),
        .mepc      (mepc),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive controls away from the edge, clock once, sample 1ns after the edge.
    task automatic step(input logic r, input logic s, input logic br, input logic jal,
                        input logic jalr, input logic [2:0] f3, input logic [31:0] im,
                        input logic [31:0] rs1, input logic z);
        @(negedge clk);
        rst = r; stall = s; is_branch = br; is_jal = jal; is_jalr = jalr;
        br_funct3 = f3; imm = im; rs1_data = rs1; alu_zero = z;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_trap,
                                input logic [63:0] e_ret);
        check_eq({tag, ".pc"}, 64'(pc), 64'(e_pc));
        check_eq({tag, ".trap"}, 64'(trap), 64'(e_trap));
        check_eq({tag, ".instret"}, instret, e_ret);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        br_funct3 = 3'b000; imm = 0; rs1_data = 0; alu_zero = 0;

        // 1: reset then free-run
        step(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step(1, 1, 0, 1, 0, 3'b000, 32'h40, 0, 0);
        expect_state("rst", 32'h0, 1'b0, 64'd0);
        check_eq("rst.mepc", 64'(mepc), 64'h0);
        check_eq("rst.pc_plus4", 64'(pc_plus4), 64'h4);
        idle(); expect_state("idle1", 32'h4, 1'b0, 64'd1);
        idle(); expect_state("idle2", 32'h8, 1'b0, 64'd2);
        idle(); expect_state("idle3", 32'hC, 1'b0, 64'd3);

        // 2: BEQ taken / not taken from pc=0x10
        step(0, 0, 0, 1, 0, 3'b000, 32'h4, 0, 0);          expect_state("jal_0x10", 32'h10, 1'b0, 64'd4);
        step(0, 0, 1, 0, 0, 3'b000, 32'h20, 0, 1);         expect_state("beq_t", 32'h30, 1'b0, 64'd5);
        step(0, 0, 0, 1, 0, 3'b000, 32'hFFFF_FFE0, 0, 0);  expect_state("jal_back", 32'h10, 1'b0, 64'd6);
        step(0, 0, 1, 0, 0, 3'b000, 32'h20, 0, 0);         expect_state("beq_nt", 32'h14, 1'b0, 64'd7);

        // 3: BLTU taken / BGE not taken from pc=0x40
        step(0, 0, 0, 1, 0, 3'b000, 32'h2C, 0, 0);         expect_state("jal_0x40", 32'h40, 1'b0, 64'd8);
        step(0, 0, 1, 0, 0, 3'b110, 32'hFFFF_FFF8, 0, 0);  expect_state("bltu_t", 32'h38, 1'b0, 64'd9);
        step(0, 0, 0, 1, 0, 3'b000, 32'h8, 0, 0);          expect_state("jal_0x40b", 32'h40, 1'b0, 64'd10);
        step(0, 0, 1, 0, 0, 3'b101, 32'hFFFF_FFF8, 0, 0);  expect_state("bge_nt", 32'h44, 1'b0, 64'd11);
        step(0, 0, 1, 0, 0, 3'b001, 32'h10, 0, 0);         expect_state("bne_t", 32'h54, 1'b0, 64'd12);
        step(0, 0, 1, 0, 0, 3'b010, 32'h10, 0, 1);         expect_state("f3_010", 32'h58, 1'b0, 64'd13);
        step(0, 0, 1, 0, 0, 3'b000, 32'h3, 0, 0);          expect_state("odd_nt", 32'h5C, 1'b0, 64'd14);

        // 4: JALR to 0x102 traps
        step(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h103, 0);    expect_state("jalr_mis", 32'h100, 1'b1, 64'd14);
        check_eq("jalr_mis.mepc", 64'(mepc), 64'h5C);
        step(0, 0, 0, 1, 0, 3'b000, 32'h40, 0, 0);         expect_state("trap_exit", 32'h100, 1'b0, 64'd14);
        idle();                                            expect_state("post_trap", 32'h104, 1'b0, 64'd15);

        // priority JALR over JAL, JALR clears bit 0
        step(0, 0, 1, 1, 1, 3'b000, 32'h4, 32'h200, 1);    expect_state("prio", 32'h204, 1'b0, 64'd16);
        step(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h301, 0);    expect_state("jalr_b0", 32'h300, 1'b0, 64'd17);

        // 5: stall with JAL pending
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 0, 3'b000, 32'h10, 0, 0);     expect_state("stall", 32'h300, 1'b0, 64'd17);
        end
        step(0, 0, 0, 1, 0, 3'b000, 32'h10, 0, 0);         expect_state("release", 32'h310, 1'b0, 64'd18);

        // 6: stall held in TRAP, then reset aborts trap
        step(0, 0, 0, 1, 0, 3'b000, 32'h2, 0, 0);          expect_state("jal_mis", 32'h100, 1'b1, 64'd18);
        check_eq("jal_mis.mepc", 64'(mepc), 64'h310);
        step(0, 1, 0, 0, 0, 3'b000, 0, 0, 0);              expect_state("trap_stall", 32'h100, 1'b1, 64'd18);
        step(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);              expect_state("trap_rst", 32'h0, 1'b0, 64'd0);
        check_eq("trap_rst.mepc", 64'(mepc), 64'h0);

        // PC wrap and a taken BGEU
        step(0, 0, 0, 1, 0, 3'b000, 32'hFFFF_FFFC, 0, 0);  expect_state("to_top", 32'hFFFF_FFFC, 1'b0, 64'd1);
        check_eq("top.pc_plus4", 64'(pc_plus4), 64'h0);
        idle();                                            expect_state("wrap", 32'h0, 1'b0, 64'd2);
        step(0, 0, 1, 0, 0, 3'b111, 32'h20, 0, 1);         expect_state("bgeu_t", 32'h20, 1'b0, 64'd3);
        step(0, 0, 1, 0, 0, 3'b100, 32'h20, 0, 1);         expect_state("blt_nt", 32'h24, 1'b0, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
